// File: rtl/boolean_vector_sequencer_pkg.sv
// +----------------------------------------------------------------------+
// | boolean_seq_pkg: shared types and code-sequencing helpers             |
// | for the Boolean-circuit vector sequencer.           Revision: 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

package boolean_seq_pkg;

  localparam int SIG_W = 16;
  localparam int VEC_W = 4;
  localparam logic [SIG_W-1:0] POLY_DEFAULT = 16'h1021;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic [VEC_W-1:0] first_code(input logic skip_en,
                                                  input logic [VEC_W-1:0] skip_code);
    return (skip_en && (skip_code == '0)) ? VEC_W'(1) : '0;
  endfunction

  function automatic logic [VEC_W-1:0] last_code(input logic skip_en,
                                                 input logic [VEC_W-1:0] skip_code);
    return (skip_en && (skip_code == '1)) ? VEC_W'(14) : VEC_W'(15);
  endfunction

  // Step past the omitted code so it is never driven onto the circuit.
  function automatic logic [VEC_W-1:0] next_code(input logic [VEC_W-1:0] vec,
                                                 input logic skip_en,
                                                 input logic [VEC_W-1:0] skip_code);
    logic [VEC_W-1:0] nxt;
    nxt = vec + VEC_W'(1);
    if (skip_en && (nxt == skip_code)) begin
      nxt = vec + VEC_W'(2);
    end
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/boolean_vector_sequencer_misr.sv
// +----------------------------------------------------------------------+
// | ef_signature_misr: folds each {E,F} sample into a 16-bit signature.  |
// |                                                     Revision: 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module ef_signature_misr
  import boolean_seq_pkg::*;
#(
  parameter logic [SIG_W-1:0] POLY = POLY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0}
            ^ (sig_q[SIG_W-1] ? POLY : '0)
            ^ {{(SIG_W-2){1'b0}}, din};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

`default_nettype wire

// File: rtl/boolean_vector_sequencer.sv
// +----------------------------------------------------------------------+
// | boolean_vector_sequencer: sweeps A..D through all codes, samples E,F |
// | after each dwell and builds a response signature.   Revision: 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module boolean_vector_sequencer
  import boolean_seq_pkg::*;
#(
  parameter int               DWELL     = 4,
  parameter bit               SKIP_EN   = 1'b0,
  parameter logic [VEC_W-1:0] SKIP_CODE = 4'b1000,
  parameter logic [SIG_W-1:0] POLY      = POLY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             E,
  input  logic             F,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  output logic             busy,
  output logic             done,
  output logic             sample_valid,
  output logic [VEC_W-1:0] sample_vec,
  output logic [1:0]       sample_ef,
  output logic [SIG_W-1:0] sig
);

  localparam int               CNT_W      = 8;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DWELL - 1);
  localparam logic [VEC_W-1:0] FIRST_CODE = first_code(SKIP_EN, SKIP_CODE);
  localparam logic [VEC_W-1:0] LAST_CODE  = last_code(SKIP_EN, SKIP_CODE);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sample_valid_q;
  logic [VEC_W-1:0] sample_vec_q;
  logic [1:0]       sample_ef_q;
  logic             sweep_start;
  logic             in_sample;

  assign in_sample = (state_q == ST_SAMPLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      vec_q          <= '0;
      cnt_q          <= '0;
      sample_valid_q <= 1'b0;
      sample_vec_q   <= '0;
      sample_ef_q    <= '0;
    end else begin
      state_q        <= state_d;
      vec_q          <= vec_d;
      cnt_q          <= cnt_d;
      sample_valid_q <= in_sample;
      if (in_sample) begin
        sample_vec_q <= vec_q;
        sample_ef_q  <= {E, F};
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    sweep_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_DRIVE;
          vec_d       = FIRST_CODE;
          cnt_d       = '0;
          sweep_start = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (!pause) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_SAMPLE;
          end
        end
      end
      ST_SAMPLE: begin
        cnt_d = '0;
        if (vec_q == LAST_CODE) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = next_code(vec_q, SKIP_EN, SKIP_CODE);
          state_d = ST_DRIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    done = (state_q == ST_DONE);
  end

  assign {A, B, C, D}  = vec_q;
  assign sample_valid  = sample_valid_q;
  assign sample_vec    = sample_vec_q;
  assign sample_ef     = sample_ef_q;

  ef_signature_misr #(
    .POLY (POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (sweep_start),
    .en  (in_sample),
    .din ({E, F}),
    .sig (sig)
  );

endmodule

`default_nettype wire

// File: tb/tb_boolean_vector_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_boolean_vector_sequencer: directed self-checking bench.           |
// |                                                     Revision: 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_boolean_vector_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: default sweep. Instance B: code 8 skipped.
  logic        start_a = 1'b0, pause_a = 1'b0, e_a, f_a;
  logic        a_a, b_a, c_a, d_a, busy_a, done_a, sv_a;
  logic [3:0]  svec_a;
  logic [1:0]  sef_a;
  logic [15:0] sig_a;
  int          mode_a = 0;

  logic        start_b = 1'b0, pause_b = 1'b0, e_b, f_b;
  logic        a_b, b_b, c_b, d_b, busy_b, done_b, sv_b;
  logic [3:0]  svec_b;
  logic [1:0]  sef_b;
  logic [15:0] sig_b;

  boolean_vector_sequencer #(.DWELL(4)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pause(pause_a), .E(e_a), .F(f_a),
    .A(a_a), .B(b_a), .C(c_a), .D(d_a), .busy(busy_a), .done(done_a),
    .sample_valid(sv_a), .sample_vec(svec_a), .sample_ef(sef_a), .sig(sig_a)
  );

  boolean_vector_sequencer #(.DWELL(4), .SKIP_EN(1'b1), .SKIP_CODE(4'b1000)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pause(pause_b), .E(e_b), .F(f_b),
    .A(a_b), .B(b_b), .C(c_b), .D(d_b), .busy(busy_b), .done(done_b),
    .sample_valid(sv_b), .sample_vec(svec_b), .sample_ef(sef_b), .sig(sig_b)
  );

  // Stand-in for the Boolean circuit under test.
  function automatic logic [1:0] ef_of(input logic [3:0] code, input int mode);
    logic [1:0] r;
    r = 2'b00;
    if (mode == 1) r = (code == 4'd0) ? 2'b01 : 2'b00;
    if (mode == 2) r = {code[3] ^ code[2], code[1] & code[0]};
    return r;
  endfunction

  assign {e_a, f_a} = ef_of({a_a, b_a, c_a, d_a}, mode_a);
  assign {e_b, f_b} = ef_of({a_b, b_b, c_b, d_b}, 2);

  function automatic logic [15:0] model_sig(input int mode, input bit skip);
    logic [15:0] s;
    s = 16'h0000;
    for (int c = 0; c < 16; c++) begin
      if (!(skip && c == 8)) begin
        s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, ef_of(4'(c), mode)};
      end
    end
    return s;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_a = 0, n_b = 0, seen8 = 0;
  int         done_rise_a = -1, done_rise_b = -1;
  logic       done_prev_a = 1'b0, done_prev_b = 1'b0;
  logic [3:0] log_vec_a [512];
  logic [1:0] log_ef_a  [512];
  int         log_cyc_a [512];
  logic [3:0] log_vec_b [64];
  int         log_cyc_b [64];

  always @(negedge clk) begin
    if (sv_a && n_a < 512) begin
      log_vec_a[n_a] = svec_a;
      log_ef_a[n_a]  = sef_a;
      log_cyc_a[n_a] = cyc;
      n_a = n_a + 1;
    end
    if (sv_b && n_b < 64) begin
      log_vec_b[n_b] = svec_b;
      log_cyc_b[n_b] = cyc;
      n_b = n_b + 1;
    end
    if (done_a && !done_prev_a) done_rise_a = cyc;
    if (done_b && !done_prev_b) done_rise_b = cyc;
    done_prev_a = done_a;
    done_prev_b = done_b;
    if ({a_b, b_b, c_b, d_b} == 4'd8 || (sv_b && svec_b == 4'd8)) seen8 = seen8 + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 2000 && cyc < target; i++) tick();
  endtask

  task automatic start_sweep_a(output int t0);
    start_a = 1'b1;
    tick();
    t0 = cyc;
    start_a = 1'b0;
  endtask

  task automatic wait_done_a();
    for (int i = 0; i < 400 && !done_a; i++) tick();
    check("done_a_timeout", 32'(done_a), 32'd1);
  endtask

  // Check one full sweep on instance A, pulses from index k0 on are shifted.
  task automatic verify_sweep_a(input string tag, input int base, input int t0, input int mode,
                                input int k0, input int shift, input logic [15:0] exp_sig);
    int errs_before;
    wait_done_a();
    check({tag, "_count"}, 32'(n_a - base), 32'd16);
    errs_before = errors;
    for (int k = 0; k < 16 && base + k < n_a; k++) begin
      check({tag, "_vec"}, 32'(log_vec_a[base + k]), 32'(k));
      check({tag, "_cyc"}, 32'(log_cyc_a[base + k]), 32'(t0 + 5 * (k + 1) + ((k >= k0) ? shift : 0)));
      check({tag, "_ef"},  32'(log_ef_a[base + k]), 32'(ef_of(4'(k), mode)));
      if (errors != errs_before) break;
    end
    check({tag, "_done_rise"}, 32'(done_rise_a), 32'(t0 + 80 + shift));
    check({tag, "_sig"}, 32'(sig_a), 32'(exp_sig));
    check({tag, "_busy_in_done"}, 32'(busy_a), 32'd0);
  endtask

  initial begin
    int t0;
    int base;
    int code8_list [15];

    // Reset state, checked before any clock edge.
    #3;
    check("rst_abcd", 32'({a_a, b_a, c_a, d_a}), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_sv",   32'(sv_a), 32'd0);
    check("rst_svec", 32'(svec_a), 32'd0);
    check("rst_sef",  32'(sef_a), 32'd0);
    check("rst_sig",  32'(sig_a), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_stays", 32'(busy_a), 32'd0);

    // E=F=0 baseline: signature stays zero.
    mode_a = 0;
    base = n_a;
    start_sweep_a(t0);
    check("t0_busy", 32'(busy_a), 32'd1);
    check("t0_vec", 32'({a_a, b_a, c_a, d_a}), 32'd0);
    verify_sweep_a("zero", base, t0, 0, 16, 0, 16'h0000);

    // {E,F}=01 on the first sample only.
    mode_a = 1;
    base = n_a;
    start_sweep_a(t0);
    wait_cyc(t0 + 5);
    check("first_sv", 32'(sv_a), 32'd1);
    check("first_sig", 32'(sig_a), 32'h0001);
    verify_sweep_a("one", base, t0, 1, 16, 0, 16'h8000);

    // Pause for 3 cycles inside code 5's dwell.
    mode_a = 2;
    base = n_a;
    start_sweep_a(t0);
    wait_cyc(t0 + 26);
    pause_a = 1'b1;
    tick();
    tick();
    check("pause_hold_vec", 32'({a_a, b_a, c_a, d_a}), 32'd5);
    tick();
    pause_a = 1'b0;
    verify_sweep_a("pause", base, t0, 2, 5, 3, model_sig(2, 1'b0));

    // start while busy at code 7 is ignored.
    base = n_a;
    start_sweep_a(t0);
    wait_cyc(t0 + 36);
    check("busy_start_vec", 32'({a_a, b_a, c_a, d_a}), 32'd7);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("busy_start_still7", 32'({a_a, b_a, c_a, d_a}), 32'd7);
    verify_sweep_a("nostart", base, t0, 2, 16, 0, model_sig(2, 1'b0));

    // start in DONE restarts with the signature cleared.
    base = n_a;
    start_sweep_a(t0);
    check("restart_sig", 32'(sig_a), 32'd0);
    check("restart_done", 32'(done_a), 32'd0);
    check("restart_vec", 32'({a_a, b_a, c_a, d_a}), 32'd0);
    verify_sweep_a("restart", base, t0, 2, 16, 0, model_sig(2, 1'b0));

    // Asynchronous reset mid-sweep at code 10.
    start_sweep_a(t0);
    wait_cyc(t0 + 52);
    check("pre_rst_vec", 32'({a_a, b_a, c_a, d_a}), 32'd10);
    #2;
    rst = 1'b1;
    #1;
    check("arst_abcd", 32'({a_a, b_a, c_a, d_a}), 32'd0);
    check("arst_busy", 32'(busy_a), 32'd0);
    check("arst_sig", 32'(sig_a), 32'd0);
    check("arst_sv", 32'(sv_a), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    base = n_a;
    start_sweep_a(t0);
    verify_sweep_a("postrst", base, t0, 2, 16, 0, model_sig(2, 1'b0));

    // Skip variant: code 8 never driven, 15 samples.
    for (int k = 0; k < 15; k++) code8_list[k] = (k < 8) ? k : k + 1;
    base = n_b;
    seen8 = 0;
    start_b = 1'b1;
    tick();
    t0 = cyc;
    start_b = 1'b0;
    for (int i = 0; i < 400 && !done_b; i++) tick();
    check("skip_done_timeout", 32'(done_b), 32'd1);
    check("skip_count", 32'(n_b - base), 32'd15);
    for (int k = 0; k < 15 && base + k < n_b; k++) begin
      check("skip_vec", 32'(log_vec_b[base + k]), 32'(code8_list[k]));
      check("skip_cyc", 32'(log_cyc_b[base + k]), 32'(t0 + 5 * (k + 1)));
    end
    check("skip_done_rise", 32'(done_rise_b), 32'(t0 + 75));
    check("skip_never8", 32'(seen8), 32'd0);
    check("skip_sig", 32'(sig_b), 32'(model_sig(2, 1'b1)));
    check("skip_last_vec", 32'({a_b, b_b, c_b, d_b}), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/boolean_vector_sequencer.md
Name: boolean_vector_sequencer

Overview:
- Upstream stimulus and response stage for the 4-input/2-output Boolean circuit (inputs A,B,C,D; outputs E,F).
- Steps A,B,C,D through all 4-bit input codes, holding each code for a programmable dwell time.
- Samples E,F at the end of each dwell and streams each sample out with the code that produced it.
- Folds every sample into a 16-bit signature, so hardware self-test replaces manual waveform inspection.

Parameters:
- DWELL, 4, clock cycles each code is held before sampling; legal range 1..255.
- SKIP_EN, 0, when 1 the code SKIP_CODE is never driven.
- SKIP_CODE, 4'b1000, code omitted when SKIP_EN=1.
- POLY, 16'h1021, signature feedback polynomial.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; honoured only in IDLE or DONE.
- pause  in  1  freeze the dwell counter while in DRIVE.
- E  in  1  circuit output E.
- F  in  1  circuit output F.
- A  out  1  circuit input A, equal to vec[3].
- B  out  1  circuit input B, equal to vec[2].
- C  out  1  circuit input C, equal to vec[1].
- D  out  1  circuit input D, equal to vec[0].
- busy  out  1  high in DRIVE or SAMPLE.
- done  out  1  high in DONE.
- sample_valid  out  1  one-cycle pulse per sampled code.
- sample_vec  out  4  code sampled, valid with sample_valid.
- sample_ef  out  2  {E,F} sampled, valid with sample_valid.
- sig  out  16  running signature.

Behaviour:
- Reset, asynchronous, immediate, also mid-sweep:
  - state=IDLE, vec=0, so A=B=C=D=0.
  - busy=0, done=0, sample_valid=0, sample_vec=0, sample_ef=0, sig=0, dwell counter=0.
- All other updates occur on the rising edge of clk.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE or DONE with start=1, at edge t0:
  - vec = first legal code: 0, or 1 if SKIP_EN=1 and SKIP_CODE=0.
  - sig cleared to 0, counter cleared to 0, done cleared to 0.
  - next state DRIVE.
- start while busy is ignored and has no effect.
- DRIVE:
  - counter increments each cycle in which pause=0 and holds when pause=1.
  - When counter==DWELL-1 and pause=0, next state SAMPLE.
  - A..D are stable for the whole of DRIVE and SAMPLE.
- SAMPLE, exactly one cycle. On its closing edge:
  - sample_ef={E,F} and sample_vec=vec are registered.
  - sample_valid=1 for the following cycle only.
  - sig <= (sig<<1) ^ (sig[15] ? POLY : 0) ^ {14'b0,E,F}.
  - If vec is the last legal code (15, or 14 if SKIP_EN=1 and SKIP_CODE=15), next state DONE and vec holds.
  - Otherwise vec advances to the next code; it advances by 2 if the next code equals SKIP_CODE and SKIP_EN=1. Counter resets to 0 and next state is DRIVE.
- pause is ignored in SAMPLE.
- DONE: done=1, sig frozen, A..D hold the last code, until start or rst.
- Timing with no pause and SKIP_EN=0:
  - Each code takes DWELL+1 cycles.
  - The k-th sample_valid pulse is high in cycle t0+(DWELL+1)(k+1).
  - done rises at edge t0+16(DWELL+1).
- Sample count per sweep: 16, or 15 with SKIP_EN=1.
- Wrap-around: vec never wraps from 15 to 0 within a sweep.

Decomposition:
- Shared package boolean_seq_pkg holds:
  - the state encoding (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3);
  - SIG_W=16;
  - VEC_W=4;
  - the default POLY.
- One sub-module, ef_signature_misr:
  - inputs clk, rst, clr, en, din[1:0]; output sig[15:0];
  - clr has priority over en.
- The FSM, dwell counter and vector advance stay in the top module.

Test Plan:
- E=F tied 0, DWELL=4, pulse start: 16 sample_valid pulses with sample_vec 0..15 in order, each 5 cycles apart; done rises 80 cycles after t0; sig=16'h0000.
- {E,F}=01 on the first sample only, 00 after: sig=16'h0001 after the first sample, 16'h8000 at done.
- SKIP_EN=1, SKIP_CODE=4'b1000: 15 pulses, code 8 never appears on A..D or sample_vec; done rises 75 cycles after t0.
- pause held 3 cycles in the middle of DRIVE for code 5: that code's sample is delayed exactly 3 cycles; all later pulses shift by 3; sig matches the unpaused run.
- start pulsed while busy at code 7: no restart; sequence and sig match the baseline; start in DONE begins a new sweep with sig cleared.
- rst asserted at code 10 between clock edges: A..D=0, busy=0, sig=0 immediately, with no clock needed; the next start runs a full 16-code sweep.
